// File: rtl/tdm_demux.sv
// Receive-side 1:4 TDM demultiplexer.
// Tracks the channel slot of an interleaved sample stream, stages the first
// three samples of each frame in shadow registers and publishes all four
// channels together on the edge that accepts the slot-3 sample. A small
// HUNT/LOCKED tracker uses frame_sync to find and police frame alignment.
module tdm_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic [1:0]       cur_ch,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

  state_e state_q;

  // Shadow registers for slots 0..2; slot 3 is taken straight from din when
  // the frame completes, so it needs no staging register.
  logic [WIDTH-1:0] stg0_q;
  logic [WIDTH-1:0] stg1_q;
  logic [WIDTH-1:0] stg2_q;

  // Decoded views of the incoming beat, only meaningful when din_valid is set.
  logic at_slot0;
  logic early_sync;
  logic missing_sync;

  // Classify the current beat against the expected slot position.
  always_comb begin
    at_slot0     = (cur_ch == 2'd0);
    early_sync   = frame_sync && !at_slot0;
    missing_sync = !frame_sync && at_slot0;
  end

  // Slot tracker, staging and output registers. Pulses (frame_valid, sync_err)
  // default low every cycle so they last exactly one cycle after their edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      cur_ch      <= 2'd0;
      locked      <= 1'b0;
      stg0_q      <= '0;
      stg1_q      <= '0;
      stg2_q      <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      // Beats without din_valid leave everything else untouched, so gaps
      // may appear anywhere inside a frame.
      if (din_valid) begin
        unique case (state_q)
          StHunt: begin
            // Unsynchronised samples are silently dropped while hunting.
            if (frame_sync) begin
              stg0_q  <= din;
              cur_ch  <= 2'd1;
              state_q <= StLocked;
              locked  <= 1'b1;
            end
          end
          StLocked: begin
            if (early_sync) begin
              // Restart the frame on the new sync; the partial frame is
              // abandoned and the published outputs are left alone. Stale
              // slot 1/2 staging is overwritten before it can be published.
              sync_err <= 1'b1;
              stg0_q   <= din;
              cur_ch   <= 2'd1;
            end else if (missing_sync) begin
              // Alignment lost: drop the sample and go back to hunting.
              sync_err <= 1'b1;
              cur_ch   <= 2'd0;
              state_q  <= StHunt;
              locked   <= 1'b0;
            end else begin
              unique case (cur_ch)
                2'd0: stg0_q <= din;
                2'd1: stg1_q <= din;
                2'd2: stg2_q <= din;
                2'd3: begin
                  // Frame complete: publish all four channels on this edge.
                  out0        <= stg0_q;
                  out1        <= stg1_q;
                  out2        <= stg2_q;
                  out3        <= din;
                  frame_valid <= 1'b1;
                end
                default: ;
              endcase
              cur_ch <= cur_ch + 2'd1;
            end
          end
          default: begin
            state_q <= StHunt;
            cur_ch  <= 2'd0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
